// File: rtl/lbr_unit.sv
// Last-branch-record buffer: circular history of retired taken branches with indexed 1-cycle reads.
// Latency 1 cycle for reads; no backpressure, everything freezes while stall is high.
// Reads return pre-edge contents; indices at or beyond the valid count read as zero.
module lbr_unit #(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_valid,
    input  logic [DATA_WIDTH-1:0] branch_from,
    input  logic [DATA_WIDTH-1:0] branch_to,
    input  logic                  read_valid,
    input  logic [INDEX_BITS-1:0] read_index,
    input  logic                  read_sel,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] LBR_data,
    output logic                  LBR_valid,
    output logic [INDEX_BITS:0]   lbr_count,
    output logic                  lbr_overflow,
    input  logic                  report
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS:0] FULL = {1'b1, {INDEX_BITS{1'b0}}};

    logic [DATA_WIDTH-1:0] from_mem [DEPTH];
    logic [DATA_WIDTH-1:0] to_mem   [DEPTH];
    logic [INDEX_BITS-1:0] wp;
    logic [INDEX_BITS-1:0] slot;
    logic                  hit;
    logic                  record;

    // Newest entry sits just below wp; older entries walk backwards from there.
    assign slot   = wp - INDEX_BITS'(1) - read_index;
    assign hit    = {1'b0, read_index} < lbr_count;
    assign record = reset && !stall && branch_valid && !clear;

    // Storage is deliberately not reset; the count gate hides stale slots.
    always_ff @(posedge clock) begin
        if (record) begin
            from_mem[wp] <= branch_from;
            to_mem[wp]   <= branch_to;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wp           <= '0;
            lbr_count    <= '0;
            lbr_overflow <= 1'b0;
            LBR_data     <= '0;
            LBR_valid    <= 1'b0;
        end else if (stall) begin
            LBR_valid <= 1'b0;
        end else begin
            LBR_valid <= read_valid;
            if (read_valid) begin
                if (!hit)
                    LBR_data <= '0;
                else if (read_sel)
                    LBR_data <= to_mem[slot];
                else
                    LBR_data <= from_mem[slot];
            end
            if (clear) begin
                wp           <= '0;
                lbr_count    <= '0;
                lbr_overflow <= 1'b0;
            end else if (branch_valid) begin
                wp <= wp + INDEX_BITS'(1);
                if (lbr_count == FULL)
                    lbr_overflow <= 1'b1;
                else
                    lbr_count <= lbr_count + (INDEX_BITS+1)'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report)
            $display("Core [%0d] LBR - wp: %0d count: %0d overflow: %b data: %h valid: %b",
                     CORE, wp, lbr_count, lbr_overflow, LBR_data, LBR_valid);
    end
`endif

endmodule

// File: tb/tb_lbr_unit.sv
// Bench for lbr_unit: directed scenarios plus a randomized run against a queue-based history model.
module tb_lbr_unit;

    logic        clock = 1'b0;
    logic        reset, stall, branch_valid, read_valid, read_sel, clear, report;
    logic [31:0] branch_from, branch_to;
    logic [3:0]  read_index;
    logic [31:0] LBR_data;
    logic        LBR_valid;
    logic [4:0]  lbr_count;
    logic        lbr_overflow;

    lbr_unit #(.CORE(0), .DATA_WIDTH(32), .INDEX_BITS(4)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_valid(branch_valid), .branch_from(branch_from), .branch_to(branch_to),
        .read_valid(read_valid), .read_index(read_index), .read_sel(read_sel),
        .clear(clear), .LBR_data(LBR_data), .LBR_valid(LBR_valid),
        .lbr_count(lbr_count), .lbr_overflow(lbr_overflow), .report(report)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] f;
        logic [31:0] t;
    } ent_t;

    ent_t        hist[$];   // hist[0] is the most recent branch
    bit          m_ovf;
    logic [31:0] m_data;
    bit          m_valid;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Drive one cycle, advance the model by the rules, sample 1 time unit after the edge.
    task automatic cyc(input bit rst_n, input bit st, input bit bv, input logic [31:0] bf,
                       input logic [31:0] bt, input bit rv, input int ri, input bit rs,
                       input bit cl);
        ent_t e;
        reset = rst_n; stall = st; branch_valid = bv; branch_from = bf; branch_to = bt;
        read_valid = rv; read_index = ri[3:0]; read_sel = rs; clear = cl;
        if (!rst_n) begin
            hist.delete(); m_ovf = 0; m_data = 0; m_valid = 0;
        end else if (st) begin
            m_valid = 0;
        end else begin
            m_valid = rv;
            if (rv) m_data = (ri < hist.size()) ? (rs ? hist[ri].t : hist[ri].f) : 32'h0;
            if (cl) begin
                hist.delete(); m_ovf = 0;
            end else if (bv) begin
                if (hist.size() == 16) begin m_ovf = 1; void'(hist.pop_back()); end
                e.f = bf; e.t = bt;
                hist.push_front(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();                                   cyc(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic rec(input logic [31:0] f, input logic [31:0] t); cyc(1, 0, 1, f, t, 0, 0, 0, 0); endtask
    task automatic rd(input int i, input bit s);             cyc(1, 0, 0, 0, 0, 1, i, s, 0); endtask
    task automatic clr();                                    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1); endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (LBR_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", LBR_data); end
        n_cmp++; if (LBR_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", LBR_valid); end
        n_cmp++; if (lbr_count !== 5'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", lbr_count); end
        n_cmp++; if (lbr_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", lbr_overflow); end
        rd(0, 0);
        n_cmp++; if (LBR_data !== 32'h0 || LBR_valid !== 1'b1)
            begin n_bad++; $display("FAIL empty_read got %h/%b want 0/1", LBR_data, LBR_valid); end
        idle();
        n_cmp++; if (LBR_valid !== 1'b0) begin n_bad++; $display("FAIL valid_pulse got %b want 0", LBR_valid); end
    endtask

    task automatic test_ordering();
        rec(32'h100, 32'h200); rec(32'h104, 32'h300); rec(32'h108, 32'h400);
        n_cmp++; if (lbr_count !== 5'd3) begin n_bad++; $display("FAIL ord_count got %0d want 3", lbr_count); end
        rd(0, 1);
        n_cmp++; if (LBR_data !== 32'h400) begin n_bad++; $display("FAIL ord_idx0_to got %h want 400", LBR_data); end
        rd(2, 0);
        n_cmp++; if (LBR_data !== 32'h100) begin n_bad++; $display("FAIL ord_idx2_from got %h want 100", LBR_data); end
        rd(1, 0);
        n_cmp++; if (LBR_data !== 32'h104) begin n_bad++; $display("FAIL ord_idx1_from got %h want 104", LBR_data); end
        rd(3, 1);
        n_cmp++; if (LBR_data !== 32'h0) begin n_bad++; $display("FAIL ord_idx3 got %h want 0", LBR_data); end
    endtask

    task automatic test_wrap();
        clr();
        for (int k = 0; k < 17; k++) rec(32'h1000 + 32'(4 * k), 32'h8000 + 32'(k));
        n_cmp++; if (lbr_count !== 5'd16) begin n_bad++; $display("FAIL wrap_count got %0d want 16", lbr_count); end
        n_cmp++; if (lbr_overflow !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf got %b want 1", lbr_overflow); end
        rd(0, 0);
        n_cmp++; if (LBR_data !== 32'h1040) begin n_bad++; $display("FAIL wrap_idx0 got %h want 1040", LBR_data); end
        rd(15, 0);
        n_cmp++; if (LBR_data !== 32'h1004) begin n_bad++; $display("FAIL wrap_idx15 got %h want 1004", LBR_data); end
        rd(15, 1);
        n_cmp++; if (LBR_data !== 32'h8001) begin n_bad++; $display("FAIL wrap_idx15_to got %h want 8001", LBR_data); end
    endtask

    task automatic test_simultaneous();
        clr();
        rec(32'h10, 32'h20); rec(32'h14, 32'h24);
        cyc(1, 0, 1, 32'hA0, 32'hB0, 1, 0, 1, 0);
        n_cmp++; if (LBR_data !== 32'h24) begin n_bad++; $display("FAIL simul_old got %h want 24", LBR_data); end
        rd(0, 1);
        n_cmp++; if (LBR_data !== 32'hB0) begin n_bad++; $display("FAIL simul_new got %h want b0", LBR_data); end
        n_cmp++; if (lbr_count !== 5'd3) begin n_bad++; $display("FAIL simul_count got %0d want 3", lbr_count); end
    endtask

    task automatic test_stall();
        logic [31:0] d0;
        logic [4:0]  c0;
        logic        o0;
        d0 = LBR_data; c0 = lbr_count; o0 = lbr_overflow;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 32'hDEAD, 32'hBEEF, 1, 0, 0, 1);
            n_cmp++; if (LBR_valid !== 1'b0 || LBR_data !== d0 || lbr_count !== c0 || lbr_overflow !== o0)
                begin n_bad++; $display("FAIL stall_hold got %h/%b/%0d/%b want %h/0/%0d/%b",
                                        LBR_data, LBR_valid, lbr_count, lbr_overflow, d0, c0, o0); end
        end
        rd(0, 1);
        n_cmp++; if (LBR_data !== 32'hB0) begin n_bad++; $display("FAIL stall_after got %h want b0", LBR_data); end
    endtask

    task automatic test_clear_reset();
        for (int k = 0; k < 17; k++) rec(32'h2000 + 32'(k), 32'h3000 + 32'(k));
        n_cmp++; if (lbr_overflow !== 1'b1) begin n_bad++; $display("FAIL clr_pre_ovf got %b want 1", lbr_overflow); end
        cyc(1, 0, 1, 32'h55, 32'h66, 1, 0, 0, 1);
        n_cmp++; if (lbr_count !== 5'd0 || lbr_overflow !== 1'b0)
            begin n_bad++; $display("FAIL clr_vs_rec got %0d/%b want 0/0", lbr_count, lbr_overflow); end
        n_cmp++; if (LBR_data !== 32'h2010) begin n_bad++; $display("FAIL clr_read got %h want 2010", LBR_data); end
        rd(0, 0);
        n_cmp++; if (LBR_data !== 32'h0) begin n_bad++; $display("FAIL clr_empty got %h want 0", LBR_data); end
        rec(32'h77, 32'h88);
        rd(0, 1);
        cyc(0, 1, 1, 32'h1, 32'h2, 1, 0, 1, 0);
        n_cmp++; if (LBR_data !== 32'h0 || LBR_valid !== 1'b0 || lbr_count !== 5'd0)
            begin n_bad++; $display("FAIL mid_reset got %h/%b/%0d want 0/0/0", LBR_data, LBR_valid, lbr_count); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            cyc(1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1), $urandom, $urandom,
                ($urandom_range(0, 2) != 0), $urandom_range(0, 15), $urandom_range(0, 1),
                ($urandom_range(0, 60) == 0));
            n_cmp++;
            if (LBR_data !== m_data || LBR_valid !== m_valid ||
                lbr_count !== 5'(hist.size()) || lbr_overflow !== m_ovf) begin
                n_bad++;
                $display("FAIL rand_%0d got %h/%b/%0d/%b want %h/%b/%0d/%b", n, LBR_data, LBR_valid,
                         lbr_count, lbr_overflow, m_data, m_valid, hist.size(), m_ovf);
            end
        end
    endtask

    initial begin
        report = 0;
        reset = 0; stall = 0; branch_valid = 0; branch_from = 0; branch_to = 0;
        read_valid = 0; read_index = 0; read_sel = 0; clear = 0;
        m_ovf = 0; m_data = 0; m_valid = 0;
        @(negedge clock);
        test_reset();
        test_ordering();
        test_wrap();
        test_simultaneous();
        test_stall();
        test_clear_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lbr_unit.md
# lbr_unit

Last-branch-record (LBR) buffer for one BRISC-V core. It captures the source and target PC of every retired taken branch/jump into a circular history of DEPTH entries. It serves indexed reads to the memory stage, and the registered result drives the writeback unit's LBR_data input; writeback selects it when opSel = 2'b10. Recording and reads freeze while the pipeline is stalled.

## Interface
- CORE, 0: core ID, used only in report output
- DATA_WIDTH, 32: PC and data width
- INDEX_BITS, 4: log2 of buffer depth; DEPTH = 2**INDEX_BITS

- clock  in  1  core clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset; state clears on a posedge where reset = 0
- stall  in  1  pipeline stall; when 1, no state changes except reset
- branch_valid  in  1  a taken branch/jump retires this cycle
- branch_from  in  DATA_WIDTH  PC of the branch instruction
- branch_to  in  DATA_WIDTH  branch target PC
- read_valid  in  1  LBR read request from memory stage
- read_index  in  INDEX_BITS  0 = most recent entry, 1 = next older, and so on
- read_sel  in  1  0 selects the from-PC, 1 selects the to-PC
- clear  in  1  empties the buffer
- LBR_data  out  DATA_WIDTH  registered read result; goes to writeback LBR_data
- LBR_valid  out  1  one-cycle pulse marking the cycle LBR_data was updated
- lbr_count  out  INDEX_BITS+1  number of valid entries, 0..DEPTH
- lbr_overflow  out  1  sticky; set once any entry has been overwritten
- report  in  1  when 1, $display a state dump each cycle, as the other pipeline units do

## Operation
- Storage holds DEPTH pairs {from, to}. A write pointer wp (INDEX_BITS bits) points to the next slot to fill.
- Record event: a posedge with reset = 1, stall = 0, branch_valid = 1 and clear = 0.
  - Writes {branch_from, branch_to} to slot wp.
  - wp advances to wp+1, wrapping modulo DEPTH.
  - lbr_count increments and saturates at DEPTH.
  - If lbr_count was already DEPTH, the oldest entry is overwritten and lbr_overflow sets to 1.
- Read event: a posedge with reset = 1, stall = 0 and read_valid = 1.
  - Physical slot = (wp - 1 - read_index) mod DEPTH, where wp is the value before this edge.
  - If read_index >= lbr_count (pre-edge value), LBR_data <= 0.
  - Otherwise LBR_data <= the from- or to-PC of that slot, chosen by read_sel.
  - LBR_valid <= 1.
  - With no read event, LBR_data holds its value and LBR_valid <= 0.
- A read and a record on the same edge: the read returns pre-write contents. A new branch becomes visible at index 0 on the next read.
- clear = 1 with stall = 0:
  - wp, lbr_count and lbr_overflow go to 0.
  - clear wins over a simultaneous record.
  - A simultaneous read still completes against pre-clear contents.
- stall = 1: no record, no read, no clear. LBR_data holds and LBR_valid <= 0.
- Storage contents are not reset. Stale data is never returned, because reads at or beyond lbr_count return 0.

## Timing
- Reset values (posedge with reset = 0): wp = 0, lbr_count = 0, lbr_overflow = 0, LBR_data = 0, LBR_valid = 0.
- Reset asserted mid-operation overrides stall, branch_valid, read_valid and clear on that edge.
- Read latency is 1 cycle: a request sampled at edge N gives LBR_data and LBR_valid valid after edge N, for the cycle N..N+1.
- A read may be issued every cycle. There is no backpressure.
- lbr_count and lbr_overflow are registered. They reflect a record event after the same edge that writes the entry.
- Pointer arithmetic is INDEX_BITS wide and modulo DEPTH. The count comparison is INDEX_BITS+1 wide.

## Test plan
- Reset and empty read: hold reset = 0 for 2 cycles, release, read index 0 → LBR_data = 0, LBR_valid pulses once, lbr_count = 0.
- Ordering: record (0x100→0x200), (0x104→0x300), (0x108→0x400).
  - Read index 0, sel 1 → 0x400.
  - Read index 2, sel 0 → 0x100.
  - Read index 3 → 0.
  - lbr_count = 3.
- Wrap and overflow (DEPTH = 16): record 17 branches with from = 0x1000+4k, k = 0..16.
  - lbr_count = 16, lbr_overflow = 1.
  - Index 0 from → 0x1040.
  - Index 15 from → 0x1004.
- Simultaneous read and record: with 2 entries, record 0xA0→0xB0 on the same edge as a read of index 0 sel 1 → returns the old newest target. The next read of index 0 sel 1 → 0xB0.
- Stall: with stall = 1, assert branch_valid, read_valid and clear for 3 cycles → lbr_count, lbr_overflow and LBR_data unchanged, LBR_valid = 0 throughout.
- Clear vs record, and reset mid-stream:
  - clear + branch_valid on the same edge → lbr_count = 0, lbr_overflow = 0.
  - Assert reset = 0 while read_valid = 1 → LBR_data = 0 and LBR_valid = 0 after that edge.
